// File: rtl/rtc_timer.sv
// Machine timer: 64-bit mtime counter advanced on rising edges of the divided
// peripheral clock, compared against mtimecmp to raise a level interrupt.
// Registers are reachable through a single-cycle valid/ready memory bus.
`timescale 1ns/1ps

module rtc_timer #(
  parameter int unsigned addr_width = 5,
  // Synchroniser depth on clock_per; legal range 2..4.
  parameter int unsigned sync_depth = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clock_per,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        timer_irq
);

  localparam int unsigned OffW = addr_width - 2;

  // Byte-lane merge of bus write data into an existing word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Tick detection
  // ---------------------------------------------------------------------------
  logic [sync_depth-1:0] sync_q;
  logic                  hist_q;
  logic                  sync_out;
  logic                  tick;

  assign sync_out = sync_q[sync_depth-1];
  assign tick     = sync_out & ~hist_q;

  // Synchroniser chain and edge history; preset high so an idle-high divider
  // produces no tick when reset is released.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[sync_depth-2:0], clock_per};
      hist_q <= sync_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic [OffW-1:0] word_off;
  logic            wr_en;
  logic            wr_mtime_lo, wr_mtime_hi;
  logic            wr_cmp_lo, wr_cmp_hi;
  logic            wr_ctrl;
  logic            unused_addr;

  assign word_off    = mem_addr[addr_width-1:2];
  assign wr_en       = mem_valid & (mem_wstrb != 4'b0000);
  assign wr_mtime_lo = wr_en & (word_off == OffW'(0));
  assign wr_mtime_hi = wr_en & (word_off == OffW'(1));
  assign wr_cmp_lo   = wr_en & (word_off == OffW'(2));
  assign wr_cmp_hi   = wr_en & (word_off == OffW'(3));
  assign wr_ctrl     = wr_en & (word_off == OffW'(4));
  assign unused_addr = ^{mem_addr[31:addr_width], mem_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Timer state
  // ---------------------------------------------------------------------------
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        enable_q, enable_d;

  // Next-state for mtime: a bus write to either word suppresses the tick.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_mtime_lo || wr_mtime_hi) begin
      if (wr_mtime_lo) mtime_d[31:0]  = merge_bytes(mtime_q[31:0],  mem_wdata, mem_wstrb);
      if (wr_mtime_hi) mtime_d[63:32] = merge_bytes(mtime_q[63:32], mem_wdata, mem_wstrb);
    end else if (tick && enable_q) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  // Next-state for mtimecmp and the enable bit.
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    enable_d   = enable_q;
    if (wr_cmp_lo) mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0],  mem_wdata, mem_wstrb);
    if (wr_cmp_hi) mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], mem_wdata, mem_wstrb);
    if (wr_ctrl && mem_wstrb[0]) enable_d = mem_wdata[0];
  end

  // Timer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= '1;
      enable_q   <= 1'b1;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      enable_q   <= enable_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path and response
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        irq_q;

  // Read mux over the pre-write register state.
  always_comb begin
    rd_word = 32'd0;
    case (word_off)
      OffW'(0): rd_word = mtime_q[31:0];
      OffW'(1): rd_word = mtime_q[63:32];
      OffW'(2): rd_word = mtimecmp_q[31:0];
      OffW'(3): rd_word = mtimecmp_q[63:32];
      OffW'(4): rd_word = {31'd0, enable_q};
      default:  rd_word = 32'd0;
    endcase
  end

  // Response strobe, captured read data and registered compare.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
      irq_q   <= 1'b0;
    end else begin
      ready_q <= mem_valid;
      rdata_q <= mem_valid ? rd_word : 32'd0;
      irq_q   <= (mtime_q >= mtimecmp_q);
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign timer_irq = irq_q;

endmodule
